// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared types and constants for the SPI transfer arbiter.
//   arb_state_t : sequencer states, also exported on the arbiter debug port
//   SPI_BYTE_W  : width of one SPI byte
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_LAUNCH,
        ARB_WAIT_DONE,
        ARB_GAP
    } arb_state_t;

endpackage

// File: rtl/spi_xfer_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. It selects the first set request bit at
//   or after the pointer and wraps from NUM_REQ-1 back to 0.
//
//   req_i    [NUM_REQ-1:0]  request levels
//   ptr_i    [IDX_W-1:0]    highest-priority index for this pick
//   onehot_o [NUM_REQ-1:0]  one-hot pick (zero when no request is set)
//   idx_o    [IDX_W-1:0]    binary index of the pick
//   any_o                   at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Index k positions after base, modulo NUM_REQ (base is always < NUM_REQ).
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int c;
        c = int'(base) + k;
        if (c >= NUM_REQ) begin
            c = c - NUM_REQ;
        end
        return IDX_W'(c);
    endfunction

    // Scan from the lowest priority to the highest so the last hit wins.
    always_comb begin
        idx_o    = '0;
        any_o    = 1'b0;
        onehot_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[wrap_idx(ptr_i, k)]) begin
                idx_o = wrap_idx(ptr_i, k);
                any_o = 1'b1;
            end
        end
        if (any_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// -----------------------------------------------------------------------------
// spi_xfer_arbiter
//   Shares one SPI master byte engine between NUM_REQ requesters. It picks a
//   requester round-robin, holds its chip select low for the whole byte,
//   launches the byte on the engine, returns the received byte with a done
//   pulse and then keeps every chip select high for the inter-transfer gap.
//
//   Handshake: a requester raises req[i] with its byte on req_data and keeps
//   it until done[i] pulses; gnt[i] is high from grant until that done. On the
//   engine side m_start is a one-cycle launch with m_din stable, accepted only
//   while m_busy is low; m_done is a one-cycle completion pulse with m_dout
//   valid in the same cycle, honoured only while waiting for completion.
//
//   Optional build macro SPI_ARB_TIMEOUT_EN adds a watchdog over the grant and
//   completion waits; on expiry it pulses err and done and returns 8'h00.
//   Without the macro err is tied low and the waits are unbounded.
//
//   Ports:
//     clk, rst_n               clock, synchronous active-low reset
//     req, req_data            per-requester request level and tx byte
//     gnt, done, rx_data, err  per-requester grant/done, rx byte, abort pulse
//     cs_n                     active-low chip selects (at most one low)
//     m_start, m_din           engine launch pulse and tx byte
//     m_busy, m_done, m_dout   engine busy, completion pulse and rx byte
//     dbg_state_o              current sequencer state
// -----------------------------------------------------------------------------
module spi_xfer_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*SPI_BYTE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [SPI_BYTE_W-1:0]         rx_data,
    output logic                          err,
    output logic [NUM_REQ-1:0]            cs_n,
    output logic                          m_start,
    output logic [SPI_BYTE_W-1:0]         m_din,
    input  logic                          m_busy,
    input  logic                          m_done,
    input  logic [SPI_BYTE_W-1:0]         m_dout,
    output arb_state_t                    dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    arb_state_t                state_q, state_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [NUM_REQ-1:0]        cs_n_q, cs_n_d;
    logic [SPI_BYTE_W-1:0]     m_din_q, m_din_d;
    logic                      m_start_q, m_start_d;
    logic [NUM_REQ-1:0]        done_q, done_d;
    logic [SPI_BYTE_W-1:0]     rx_q, rx_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      finish;

    logic [NUM_REQ-1:0]        pick_onehot;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      err_q, err_d;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cs_n_d    = cs_n_q;
        m_din_d   = m_din_q;
        m_start_d = 1'b0;
        done_d    = '0;
        rx_d      = rx_q;
        gap_d     = gap_q;
        finish    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    // Chip select goes low together with the grant.
                    cs_n_d  = ~pick_onehot;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                m_din_d = req_data[SPI_BYTE_W*int'(idx_q) +: SPI_BYTE_W];
                if (!m_busy) begin
                    // m_start is registered, so it is high exactly while in LAUNCH.
                    m_start_d = 1'b1;
                    state_d   = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                state_d = ARB_WAIT_DONE;
            end
            ARB_WAIT_DONE: begin
                if (m_done) begin
                    rx_d   = m_dout;
                    done_d = gnt_q;
                    finish = 1'b1;
                end
            end
            ARB_GAP: begin
                if (gap_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

`ifdef SPI_ARB_TIMEOUT_EN
        err_d = 1'b0;
        tmo_d = '0;
        // A real completion in the same cycle as expiry takes precedence.
        if ((state_q == ARB_GRANT || state_q == ARB_WAIT_DONE) && !finish) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                err_d     = 1'b1;
                done_d    = gnt_q;
                rx_d      = '0;
                m_start_d = 1'b0;
                finish    = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif

        if (finish) begin
            cs_n_d  = '1;
            gnt_d   = '0;
            ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = ARB_GAP;
        end

`ifdef SPI_ARB_TIMEOUT_EN
        // The watchdog restarts from zero on every state entry.
        if (state_d != state_q) begin
            tmo_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cs_n_q    <= '1;
            m_din_q   <= '0;
            m_start_q <= 1'b0;
            done_q    <= '0;
            rx_q      <= '0;
            gap_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cs_n_q    <= cs_n_d;
            m_din_q   <= m_din_d;
            m_start_q <= m_start_d;
            done_q    <= done_d;
            rx_q      <= rx_d;
            gap_q     <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rx_data     = rx_q;
    assign cs_n        = cs_n_q;
    assign m_start     = m_start_q;
    assign m_din       = m_din_q;
    assign dbg_state_o = state_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
module tb_spi_xfer_arbiter;
    import spi_pkg::*;

    localparam int N   = 4;
    localparam int GAP = 4;
    localparam int TMO = 16;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   gnt, done, cs_n;
    logic [7:0]     rx_data, m_din, m_dout;
    logic           err, m_start, m_busy, m_done;
    arb_state_t     dbg_state;

    logic eng_busy, eng_done, busy_force, stray_done;
    assign m_busy = eng_busy | busy_force;
    assign m_done = eng_done | stray_done;

    spi_xfer_arbiter #(
        .NUM_REQ        (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .rx_data     (rx_data),
        .err         (err),
        .cs_n        (cs_n),
        .m_start     (m_start),
        .m_din       (m_din),
        .m_busy      (m_busy),
        .m_done      (m_done),
        .m_dout      (m_dout),
        .dbg_state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    logic [7:0] tx_tab [N];
    logic [7:0] rx_tab [N];

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int low_idx(input logic [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) low_idx = i;
        end
    endfunction

    // First requester at or after ptr, wrapping.
    function automatic int rr_model(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // ---------------- engine model (stimulus) ----------------
    int         eng_lat  = 3;
    bit         eng_mute = 1'b0;
    int         eng_cnt  = 0;
    logic [7:0] eng_rx;

    initial begin
        logic st, rs;
        logic [N-1:0] csl;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        m_dout   = 8'h00;
        eng_rx   = 8'h00;
        forever begin
            @(negedge clk);
            st  = m_start;
            rs  = rst_n;
            csl = ~cs_n;
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (!rs) begin
                eng_cnt  = 0;
                eng_busy = 1'b0;
            end else if (st) begin
                eng_busy = 1'b1;
                eng_cnt  = eng_lat;
                eng_rx   = (csl != '0) ? rx_tab[low_idx(csl)] : 8'h00;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_busy = 1'b0;
                    if (!eng_mute) begin
                        eng_done = 1'b1;
                        m_dout   = eng_rx;
                    end
                end
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    // Entry: {err, rx byte, done one-hot}, due the cycle after it is pushed.
    logic [N+8:0] exp_q[$];
    int           grant_log[$];
    int           m_ptr     = 0;
    int           owner     = -1;
    bit           started   = 1'b0;
    int           ph_cnt    = 0;
    bit           had_xfer  = 1'b0;
    int           hi_run    = 0;
    logic [N-1:0] idle0_req = '0;
    logic [N-1:0] prev_req  = '0;
    logic         prev_busy = 1'b0;
    logic         prev_rst  = 1'b1;

    always @(negedge clk) begin : compare
        logic [N+8:0] e;
        logic [N-1:0] cs_low;
        bit           exp_start, ended;
        int           pick;
        cs_low = ~cs_n;
        if (!prev_rst) begin
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_done", 32'(done), 32'h0);
            check("rst_rx", 32'(rx_data), 32'h0);
            check("rst_err", 32'(err), 32'h0);
            check("rst_cs_n", 32'(cs_n), 32'hF);
            check("rst_m_start", 32'(m_start), 32'h0);
            check("rst_m_din", 32'(m_din), 32'h0);
            check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
            m_ptr     = 0;
            owner     = -1;
            started   = 1'b0;
            ph_cnt    = 0;
            had_xfer  = 1'b0;
            hi_run    = 0;
            idle0_req = '0;
            exp_q.delete();
        end else if (rst_n) begin
            check("gnt_vs_cs", 32'(gnt), 32'(cs_low));
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("done", 32'(done), 32'(e[N-1:0]));
                check("rx_data", 32'(rx_data), 32'(e[N+7:N]));
                check("err", 32'(err), 32'(e[N+8]));
                check("cs_released", 32'(cs_n), 32'hF);
            end else begin
                check("done_quiet", 32'(done), 32'h0);
                check("err_quiet", 32'(err), 32'h0);
            end

            exp_start = (owner >= 0) && !started && !prev_busy;
            check("m_start", 32'(m_start), 32'(exp_start));
            if (exp_start) begin
                check("m_din", 32'(m_din), 32'(tx_tab[owner]));
                started = 1'b1;
                ph_cnt  = 0;
            end

            if (owner < 0) begin
                if (cs_low != '0) begin
                    pick = rr_model(m_ptr, prev_req);
                    check("grant_pick", 32'(cs_low), (pick >= 0) ? 32'(oh(pick)) : 32'h0);
                    if (had_xfer) begin
                        if (idle0_req != '0) check("gap_exact", 32'(hi_run), 32'(GAP + 1));
                        else check("gap_min", 32'(hi_run > GAP + 1), 32'h1);
                    end
                    grant_log.push_back(low_idx(cs_low));
                    owner   = (pick >= 0) ? pick : low_idx(cs_low);
                    started = 1'b0;
                    ph_cnt  = 0;
                end else begin
                    hi_run++;
                    if (hi_run == GAP + 1) idle0_req = req;
                end
            end

            if (owner >= 0) begin
                check("cs_owner", 32'(cs_low), 32'(oh(owner)));
                ended = 1'b0;
                if (started && !exp_start && m_done) begin
                    exp_q.push_back({1'b0, m_dout, oh(owner)});
                    ended = 1'b1;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                if (!ended && !exp_start) begin
                    ph_cnt++;
                    if (ph_cnt == TMO) begin
                        exp_q.push_back({1'b1, 8'h00, oh(owner)});
                        ended = 1'b1;
                    end
                end
`endif
                if (ended) begin
                    m_ptr     = (owner + 1) % N;
                    owner     = -1;
                    started   = 1'b0;
                    had_xfer  = 1'b1;
                    hi_run    = 0;
                    idle0_req = '0;
                end
            end
        end
        prev_rst  = rst_n;
        prev_req  = req;
        prev_busy = m_busy;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tx();
        req_data = {tx_tab[3], tx_tab[2], tx_tab[1], tx_tab[0]};
    endtask

    task automatic wait_dones(input int n, input int max_cyc, input string name,
                              output logic [N-1:0] d, output logic [7:0] rx);
        int seen = 0;
        int cyc  = 0;
        d  = '0;
        rx = '0;
        while (seen < n && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                seen++;
                d  = done;
                rx = rx_data;
            end
        end
        check({name, "_done_count"}, 32'(seen), 32'(n));
    endtask

    task automatic wait_start(input int max_cyc, input string name, output int lat,
                              output logic [7:0] din, output logic [N-1:0] cs_seen);
        bit hit = 1'b0;
        lat = 0;
        din = '0;
        cs_seen = '1;
        while (!hit && lat < max_cyc) begin
            @(negedge clk);
            if (m_start) begin
                hit = 1'b1;
                din = m_din;
                cs_seen = cs_n;
            end else begin
                lat++;
            end
        end
        check({name, "_start_seen"}, 32'(hit), 32'h1);
    endtask

    task automatic check_order(input string name, input int exp_arr[$]);
        check({name, "_len"}, 32'(grant_log.size()), 32'(exp_arr.size()));
        for (int k = 0; k < exp_arr.size() && k < grant_log.size(); k++) begin
            check(name, 32'(grant_log[k]), 32'(exp_arr[k]));
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [N-1:0] d;
        logic [7:0]   rx, din;
        logic [N-1:0] cs_seen;
        int           lat, starts;
        rst_n      = 1'b0;
        req        = '0;
        busy_force = 1'b0;
        stray_done = 1'b0;
        tx_tab = '{8'h11, 8'hA5, 8'h5A, 8'hC3};
        rx_tab = '{8'h81, 8'h3C, 8'h7E, 8'hE7};
        set_tx();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Fairness from pointer 0 with every requester pending.
        grant_log.delete();
        eng_lat = 2;
        req = 4'b1111;
        wait_dones(5, 400, "fair", d, rx);
        tick();
        req = '0;
        check_order("fair_order", '{0, 1, 2, 3, 0});
        repeat (8) tick();

        // Single request from requester 1.
        eng_lat = 3;
        req = 4'b0010;
        wait_start(20, "single", lat, din, cs_seen);
        check("single_latency", 32'(lat), 32'd2);
        check("single_m_din", 32'(din), 32'hA5);
        check("single_cs_n", 32'(cs_seen), 32'b1101);
        wait_dones(1, 50, "single", d, rx);
        check("single_done", 32'(d), 32'b0010);
        check("single_rx", 32'(rx), 32'h3C);
        tick();
        req = '0;
        repeat (8) tick();

        // Engine busy while granted.
        busy_force = 1'b1;
        req = 4'b0100;
        starts = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_start) starts++;
        end
        check("busy_no_start", 32'(starts), 32'h0);
        check("busy_cs_n", 32'(cs_n), 32'b1011);
        check("busy_gnt", 32'(gnt), 32'b0100);
        tick();
        busy_force = 1'b0;
        wait_dones(1, 50, "busy", d, rx);
        check("busy_done", 32'(d), 32'b0100);
        check("busy_rx", 32'(rx), 32'h7E);
        tick();
        req = '0;
        repeat (8) tick();

        // Requester 0 drops its request while granted.
        grant_log.delete();
        req = 4'b0011;
        while (cs_n == 4'b1111) @(negedge clk);
        tick();
        req = 4'b0010;
        wait_dones(1, 50, "drop0", d, rx);
        check("drop0_done", 32'(d), 32'b0001);
        check("drop0_rx", 32'(rx), 32'h81);
        wait_dones(1, 50, "drop1", d, rx);
        check("drop1_done", 32'(d), 32'b0010);
        tick();
        req = '0;
        check_order("drop_order", '{0, 1});
        repeat (8) tick();

        // Stray completion pulse while idle.
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_done_ignored", 32'(done), 32'h0);
        repeat (4) tick();

        // Reset in the middle of a completion wait.
        eng_lat = 8;
        req = 4'b0100;
        wait_start(20, "rstmid", lat, din, cs_seen);
        tick();
        tick();
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_cs_n", 32'(cs_n), 32'hF);
        check("rstmid_gnt", 32'(gnt), 32'h0);
        check("rstmid_state", 32'(dbg_state), 32'(ARB_IDLE));
        tick();
        grant_log.delete();
        eng_lat = 3;
        req = 4'b1001;
        wait_dones(1, 50, "after_rst0", d, rx);
        check("after_rst_first", 32'(d), 32'b0001);
        tick();
        req = 4'b1000;
        wait_dones(1, 50, "after_rst3", d, rx);
        check("after_rst_second", 32'(d), 32'b1000);
        tick();
        req = '0;
        check_order("after_rst_order", '{0, 3});
        repeat (8) tick();

`ifdef SPI_ARB_TIMEOUT_EN
        // Engine never completes for requester 1; requester 2 is next.
        eng_mute = 1'b1;
        req = 4'b0110;
        wait_start(20, "tmo", lat, din, cs_seen);
        lat = 0;
        while (!err && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        // 16 counted wait cycles, then the registered err/done pulse.
        check("tmo_cycles", 32'(lat), 32'(TMO + 1));
        check("tmo_done", 32'(done), 32'b0010);
        check("tmo_rx", 32'(rx_data), 32'h00);
        tick();
        eng_mute = 1'b0;
        req = 4'b0100;
        wait_dones(1, 80, "tmo_next", d, rx);
        check("tmo_next_done", 32'(d), 32'b0100);
        tick();
        req = '0;
        repeat (8) tick();
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
